// File: rtl/cache_fill_responder.sv
// Memory-side responder for the two-way cache: fetches a four-word line in critical-word-first
// wrap order, buffers it, replays it as a gap-free burst, and services single-word writes.
module cache_fill_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic        sdram_req,
    input  logic        sdram_rw,
    input  logic [31:0] sdram_addr,
    input  logic [15:0] data_to_sdram,
    input  logic        sdram_beu,
    input  logic        sdram_bel,
    output logic        sdram_fill,
    output logic [15:0] data_from_sdram,
    output logic        sdram_wr_ack,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic        mem_busy,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_ISSUE = 3'd1;
    localparam logic [2:0] RD_WAIT  = 3'd2;
    localparam logic [2:0] BURST    = 3'd3;
    localparam logic [2:0] WR_CMD   = 3'd4;
    localparam logic [2:0] WR_ACK   = 3'd5;

    logic [2:0]  state_q;
    logic [28:0] line_q;
    logic [1:0]  crit_q;
    logic [1:0]  issue_cnt_q;
    logic [1:0]  ret_cnt_q;
    logic [1:0]  burst_cnt_q;
    logic [15:0] line_buf [4];

    logic        rd_accept;
    logic        wr_accept;
    logic        ret_take;
    logic [1:0]  next_word;
    logic [1:0]  burst_nxt;
    logic        unused_addr_bit;

    assign unused_addr_bit = sdram_addr[0];

    always_comb begin
        rd_accept = mem_rd && !mem_busy;
        wr_accept = mem_wr && !mem_busy;
        ret_take  = mem_rvalid && (state_q == RD_ISSUE || state_q == RD_WAIT);
        next_word = crit_q + issue_cnt_q + 2'd1;
        burst_nxt = burst_cnt_q + 2'd1;
    end

    // Returned words land in arrival order, which is already the wrap order of the burst.
    always_ff @(posedge clk) begin
        if (ret_take) begin
            line_buf[ret_cnt_q] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            line_q          <= '0;
            crit_q          <= '0;
            issue_cnt_q     <= '0;
            ret_cnt_q       <= '0;
            burst_cnt_q     <= '0;
            sdram_fill      <= 1'b0;
            data_from_sdram <= '0;
            sdram_wr_ack    <= 1'b0;
            mem_rd          <= 1'b0;
            mem_wr          <= 1'b0;
            mem_addr        <= '0;
            mem_be          <= '0;
            mem_wdata       <= '0;
        end else begin
            if (ret_take) begin
                ret_cnt_q <= ret_cnt_q + 2'd1;
            end

            unique case (state_q)
                IDLE: begin
                    if (sdram_req) begin
                        line_q      <= sdram_addr[31:3];
                        crit_q      <= sdram_addr[2:1];
                        mem_wdata   <= data_to_sdram;
                        mem_be      <= {sdram_beu, sdram_bel};
                        issue_cnt_q <= '0;
                        ret_cnt_q   <= '0;
                        if (sdram_rw) begin
                            mem_rd   <= 1'b1;
                            mem_addr <= {sdram_addr[31:3], sdram_addr[2:1], 1'b0};
                            state_q  <= RD_ISSUE;
                        end else begin
                            mem_wr   <= 1'b1;
                            mem_addr <= {sdram_addr[31:1], 1'b0};
                            state_q  <= WR_CMD;
                        end
                    end
                end

                RD_ISSUE: begin
                    if (rd_accept) begin
                        issue_cnt_q <= issue_cnt_q + 2'd1;
                        if (issue_cnt_q == 2'd3) begin
                            mem_rd  <= 1'b0;
                            state_q <= RD_WAIT;
                        end else begin
                            mem_addr <= {line_q, next_word, 1'b0};
                        end
                    end
                end

                RD_WAIT: begin
                    if (mem_rvalid && ret_cnt_q == 2'd3) begin
                        // buf[0] is already stored; buf[3] is written on this same edge.
                        sdram_fill      <= 1'b1;
                        data_from_sdram <= line_buf[0];
                        burst_cnt_q     <= '0;
                        state_q         <= BURST;
                    end
                end

                BURST: begin
                    sdram_fill <= 1'b0;
                    if (burst_cnt_q == 2'd3) begin
                        burst_cnt_q <= '0;
                        state_q     <= IDLE;
                    end else begin
                        data_from_sdram <= line_buf[burst_nxt];
                        burst_cnt_q     <= burst_nxt;
                    end
                end

                WR_CMD: begin
                    if (wr_accept) begin
                        mem_wr       <= 1'b0;
                        sdram_wr_ack <= 1'b1;
                        state_q      <= WR_ACK;
                    end
                end

                WR_ACK: begin
                    if (!sdram_req) begin
                        sdram_wr_ack <= 1'b0;
                        state_q      <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_responder.sv
// Directed bench for cache_fill_responder with a behavioural word-wide memory model
// (read data = low 16 bits of the word address).
module tb_cache_fill_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sdram_req;
    logic        sdram_rw;
    logic [31:0] sdram_addr;
    logic [15:0] data_to_sdram;
    logic        sdram_beu;
    logic        sdram_bel;
    logic        sdram_fill;
    logic [15:0] data_from_sdram;
    logic        sdram_wr_ack;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic        mem_busy;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    cache_fill_responder dut (
        .clk             (clk),
        .reset           (reset),
        .sdram_req       (sdram_req),
        .sdram_rw        (sdram_rw),
        .sdram_addr      (sdram_addr),
        .data_to_sdram   (data_to_sdram),
        .sdram_beu       (sdram_beu),
        .sdram_bel       (sdram_bel),
        .sdram_fill      (sdram_fill),
        .data_from_sdram (data_from_sdram),
        .sdram_wr_ack    (sdram_wr_ack),
        .mem_rd          (mem_rd),
        .mem_wr          (mem_wr),
        .mem_addr        (mem_addr),
        .mem_be          (mem_be),
        .mem_wdata       (mem_wdata),
        .mem_busy        (mem_busy),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory model state shared with the stimulus process.
    int          cyc = 0;
    int          lat_q = 1;
    int          mode_q = 0;      // 0 no busy, 1 random busy, 2 stall 3 cycles on 2nd command
    int          stall_left = 0;
    int          acc_cnt = 0;
    logic [31:0] exp_issue [4];
    logic [15:0] exp_word [4];
    logic [15:0] rq_data [$];
    int          rq_due [$];

    // Inputs are stable from #1 after an edge until the next edge, so sample here.
    always @(negedge clk) begin
        if (mem_rd && !reset) begin
            if (acc_cnt < 4) check("rd_addr", mem_addr, exp_issue[acc_cnt]);
            else check("rd_extra", {31'b0, mem_rd}, 32'd0);
            if (!mem_busy) begin
                rq_data.push_back(mem_addr[15:0]);
                rq_due.push_back(cyc + lat_q);
                acc_cnt++;
            end
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0;
        if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rq_data.pop_front();
            void'(rq_due.pop_front());
        end
        if (mode_q == 1) begin
            mem_busy = 1'($urandom_range(0, 1));
        end else if (mode_q == 2 && acc_cnt == 1 && stall_left > 0) begin
            mem_busy = 1'b1;
            stall_left--;
        end else begin
            mem_busy = 1'b0;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_fill"}, {31'b0, sdram_fill}, 32'd0);
        check({tag, "_data"}, {16'b0, data_from_sdram}, 32'd0);
        check({tag, "_ack"}, {31'b0, sdram_wr_ack}, 32'd0);
        check({tag, "_rd"}, {31'b0, mem_rd}, 32'd0);
        check({tag, "_wr"}, {31'b0, mem_wr}, 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_be"}, {30'b0, mem_be}, 32'd0);
        check({tag, "_wdata"}, {16'b0, mem_wdata}, 32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_all_zero(tag);
    endtask

    // rst_at: 0 none, 1 reset during burst word 1, 2 reset once all four commands accepted
    task automatic run_read(input logic [31:0] addr, input int lat, input int mode,
                            input int rst_at, input bit chk_fill_cycle);
        int  n;
        bit  got;
        logic [1:0] w;
        for (int i = 0; i < 4; i++) begin
            w = addr[2:1] + 2'(i);
            exp_issue[i] = {addr[31:3], w, 1'b0};
            exp_word[i]  = {addr[15:3], w, 1'b0};
        end
        lat_q = lat;
        mode_q = mode;
        stall_left = 3;
        acc_cnt = 0;
        sdram_req = 1'b1;
        sdram_rw = 1'b1;
        sdram_addr = addr;
        n = 0;
        got = 1'b0;
        while (!got && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (rst_at == 2 && acc_cnt == 4) begin
                sdram_req = 1'b0;
                pulse_reset("rst_wait");
                mode_q = 0;
                return;
            end
            if (sdram_fill) got = 1'b1;
        end
        sdram_req = 1'b0;
        check("fill_seen", {31'b0, got}, 32'd1);
        if (!got) begin
            mode_q = 0;
            return;
        end
        if (chk_fill_cycle) check("fill_cycle", n, 6);
        check("word0", {16'b0, data_from_sdram}, {16'b0, exp_word[0]});
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            if (rst_at == 1 && k == 1) begin
                pulse_reset("rst_burst");
                mode_q = 0;
                return;
            end
            check("fill_once", {31'b0, sdram_fill}, 32'd0);
            check("word_k", {16'b0, data_from_sdram}, {16'b0, exp_word[k]});
        end
        @(posedge clk); #1;
        check("hold_w3", {16'b0, data_from_sdram}, {16'b0, exp_word[3]});
        check("idle_fill", {31'b0, sdram_fill}, 32'd0);
        check("accepted", acc_cnt, 4);
        mode_q = 0;
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [15:0] d,
                             input logic beu, input logic bel);
        mode_q = 0;
        sdram_req = 1'b1;
        sdram_rw = 1'b0;
        sdram_addr = addr;
        data_to_sdram = d;
        sdram_beu = beu;
        sdram_bel = bel;
        @(posedge clk); #1;
        check("wr_strobe", {31'b0, mem_wr}, 32'd1);
        check("wr_addr", mem_addr, {addr[31:1], 1'b0});
        check("wr_be", {30'b0, mem_be}, {30'b0, beu, bel});
        check("wr_data", {16'b0, mem_wdata}, {16'b0, d});
        check("wr_ack_early", {31'b0, sdram_wr_ack}, 32'd0);
        @(posedge clk); #1;
        check("wr_drop", {31'b0, mem_wr}, 32'd0);
        check("wr_ack", {31'b0, sdram_wr_ack}, 32'd1);
        repeat (2) begin
            @(posedge clk); #1;
            check("wr_ack_hold", {31'b0, sdram_wr_ack}, 32'd1);
        end
        sdram_req = 1'b0;
        @(posedge clk); #1;
        check("wr_ack_clr", {31'b0, sdram_wr_ack}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        sdram_req = 1'b0;
        sdram_rw = 1'b0;
        sdram_addr = '0;
        data_to_sdram = '0;
        sdram_beu = 1'b0;
        sdram_bel = 1'b0;
        mem_busy = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        run_read(32'h0000_1234, 1, 0, 0, 1'b1);
        @(posedge clk); #1;
        run_read(32'h0000_1234, 1, 2, 0, 1'b0);
        @(posedge clk); #1;
        run_read(32'hDEAD_BEEE, 1, 0, 0, 1'b1);
        @(posedge clk); #1;

        run_write(32'h0000_00A6, 16'hBEEF, 1'b1, 1'b0);
        @(posedge clk); #1;
        run_write(32'h1234_5671, 16'h5A5A, 1'b0, 1'b0);
        @(posedge clk); #1;
        run_write(32'h0000_0010, 16'h1357, 1'b1, 1'b1);
        @(posedge clk); #1;

        run_read(32'h0000_1234, 1, 0, 1, 1'b0);
        run_read(32'h0000_4322, 1, 0, 0, 1'b1);
        @(posedge clk); #1;
        run_read(32'h0000_8006, 4, 0, 2, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("stray_rvalid_fill", {31'b0, sdram_fill}, 32'd0);
        run_read(32'h0000_ABCA, 4, 0, 0, 1'b0);
        @(posedge clk); #1;

        for (int t = 0; t < 1000; t++) begin
            run_read($urandom, 4, 1, 0, 1'b0);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_fill_responder.md
# cache_fill_responder

Memory-side responder for the two-way CPU cache's SDRAM request interface. It accepts cache read requests, fetches the four-word cacheline from a word-wide memory command port in critical-word-first wrap order, buffers it, then delivers it as one gap-free four-cycle burst marked by a single `sdram_fill` pulse. It also services single-word writes with byte enables. It sits between the cache and the SDRAM controller/arbiter.

## Interface
- No parameters.
- `clk` in 1: sole clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `sdram_req` in 1: cache request, held until serviced.
- `sdram_rw` in 1: 1 = line read, 0 = word write.
- `sdram_addr` in 32: byte address; [31:3] line, [2:1] critical word (reads) or target word (writes).
- `data_to_sdram` in 16: write data.
- `sdram_beu` / `sdram_bel` in 1 each: active-high byte enables [15:8] / [7:0] for writes.
- `sdram_fill` out 1: one-cycle pulse marking burst word 0.
- `data_from_sdram` out 16: burst data.
- `sdram_wr_ack` out 1: write done, held until `sdram_req` low.
- `mem_rd` / `mem_wr` out 1 each: memory command strobes.
- `mem_addr` out 32: word byte address, bit 0 = 0.
- `mem_be` out 2: {upper, lower} byte enables.
- `mem_wdata` out 16: write data.
- `mem_busy` in 1: command accepted only in a cycle with strobe=1 and `mem_busy`=0.
- `mem_rvalid` in 1 / `mem_rdata` in 16: read returns, in issue order, ≥1 cycle after acceptance.

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, BURST, WR_CMD, WR_ACK.
- IDLE: on `sdram_req`=1, latch `sdram_addr`, `data_to_sdram`, enables; `sdram_rw`=1 → RD_ISSUE, else → WR_CMD. Stray `mem_rvalid` ignored.
- RD_ISSUE: 2-bit issue counter i=0..3; `mem_addr` = {line[31:3], (crit+i)[1:0], 0}, 2-bit wrap. `mem_rd`, `mem_addr` held stable while `mem_busy`=1; i advances per accepted command. After 4th acceptance → RD_WAIT (drop `mem_rd`).
- Return counter j: each `mem_rvalid` in RD_ISSUE/RD_WAIT stores `mem_rdata` into buf[j], j++. Issue and return may coincide. 4th return → BURST.
- BURST: 2-bit counter k; `data_from_sdram` = buf[k] each cycle, k=0..3 on consecutive cycles; `sdram_fill`=1 only with k=0. After k=3 → IDLE. `data_from_sdram` then holds buf[3].
- WR_CMD: `mem_wr`=1, `mem_addr` = {addr[31:1],0}, `mem_be` = {beu, bel}, `mem_wdata` latched; held until accepted → WR_ACK.
- WR_ACK: `sdram_wr_ack`=1 while `sdram_req`=1; when `sdram_req`=0, ack drops that edge → IDLE.
- Write with both enables 0: command still issued, `mem_be`=00.
- `mem_rvalid` beyond four per line: ignored.

## Timing
- Reset: all outputs 0 (`sdram_fill`, `data_from_sdram`, `sdram_wr_ack`, `mem_rd`, `mem_wr`, `mem_addr`, `mem_be`, `mem_wdata`), counters 0, state IDLE, effective next cycle; reset mid-read/burst/write abandons the operation, later returns ignored.
- All outputs registered.
- Read, request sampled at edge of cycle A, `mem_busy`=0, return latency 1: `mem_rd` cycles A+1..A+4, returns A+2..A+5, `sdram_fill` A+6, words A+6..A+9, IDLE at A+10.
- General: `sdram_fill` asserted the cycle after the 4th `mem_rvalid` is sampled.
- `sdram_req` is still high when IDLE is re-entered only on protocol violation; the cache drops it the cycle after the fill.
- Write, no stall: `mem_wr` A+1, `sdram_wr_ack` from A+2 until the cycle after `sdram_req` is sampled low.

## Test plan
- Read addr 0x0000_1234 (crit 2), memory word = low addr bits: `mem_addr` 0x1234, 0x1236, 0x1230, 0x1232; fill pulse with 0x1234, then 0x1236, 0x1230, 0x1232 consecutive; fill at A+6.
- Same read, `mem_busy` high 3 cycles on 2nd command: `mem_addr` holds 0x1236 throughout the stall; burst order unchanged; fill one cycle wide, no data gaps.
- Return latency 4, random busy: 1000 reads, random addresses; burst always contiguous and in wrap order, `mem_rd` never asserted beyond 4 accepted commands.
- Write 0x0000_00A6, data 0xBEEF, beu=1, bel=0: `mem_addr` 0xA6, `mem_be` 10, `mem_wdata` 0xBEEF; ack held until req drops, clears next edge.
- Reset asserted during BURST k=1: next cycle all outputs 0, IDLE; a following read completes correctly, late returns ignored.
